// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb
//   Round-robin arbiter that shares the single SDRAM read port among N
//   game-side ROM requesters. Only one transaction is in flight at a time.
//   The controller's read data bus goes to all clients in parallel, so this
//   block only routes the ack/rdy strobes. New grants are held off while a
//   ROM download is running. A watchdog aborts a WAIT that never sees
//   data_rdy.
//
// Ports
//   clk_rom      clock
//   rst          asynchronous reset, active high
//   req[N]       per-client request level, held until that client's ack
//   addr[N*AW]   client i address at [i*AW +: AW]
//   ack[N]       one-cycle pulse: the SDRAM controller accepted the request
//   rdy[N]       one-cycle pulse: read data is valid for that client
//   downloading  ROM download in progress, blocks new grants
//   sdram_req    request to the SDRAM controller
//   sdram_addr   address latched from the granted client
//   sdram_ack    controller accepted the request
//   data_rdy     controller read data valid
//   busy         high in REQ or WAIT
//   timeout_err  one-cycle pulse when the watchdog aborts a transaction
module jtframe_rom_arb #(
    parameter int N       = 4,
    parameter int AW      = 22,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk_rom,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    rdy,
    input  logic            downloading,
    output logic            sdram_req,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    output logic            busy,
    output logic            timeout_err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} st_t;

    st_t                  st, st_nx;
    logic [PW-1:0]        gnt, gnt_nx;
    logic [PW-1:0]        ptr, ptr_nx;
    logic [9:0]           wcnt, wcnt_nx;
    logic                 sreq_nx;
    logic [AW-1:0]        saddr_nx;
    logic [N-1:0]         ack_nx, rdy_nx;
    logic                 terr_nx;

    logic [N-1:0][AW-1:0] caddr;
    logic [PW-1:0]        sel;
    logic                 found;
    logic [PW:0]          scan;

    assign caddr = addr;
    assign busy  = (st != IDLE);

    // First requester at or after ptr, wrapping modulo N. scan carries one
    // extra bit so ptr+k never overflows before the wrap subtraction.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr} + (PW+1)'(k);
            if (scan >= (PW+1)'(N)) scan = scan - (PW+1)'(N);
            if (!found && req[scan[PW-1:0]]) begin
                found = 1'b1;
                sel   = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        st_nx    = st;
        gnt_nx   = gnt;
        ptr_nx   = ptr;
        wcnt_nx  = wcnt;
        sreq_nx  = sdram_req;
        saddr_nx = sdram_addr;
        ack_nx   = '0;
        rdy_nx   = '0;
        terr_nx  = 1'b0;
        case (st)
            IDLE: begin
                // data_rdy is ignored here: a stray strobe after a reset or
                // an abort has no owner.
                if (!downloading && found) begin
                    st_nx    = REQ;
                    sreq_nx  = 1'b1;
                    saddr_nx = caddr[sel];
                    gnt_nx   = sel;
                    ptr_nx   = (sel == PW'(N-1)) ? '0 : sel + 1'b1;
                end
            end
            REQ: begin
                // No watchdog here: the controller may stall for refresh.
                if (sdram_ack) begin
                    sreq_nx     = 1'b0;
                    ack_nx[gnt] = 1'b1;
                    if (data_rdy) begin
                        rdy_nx[gnt] = 1'b1;
                        st_nx       = IDLE;
                    end else begin
                        st_nx   = WAIT;
                        wcnt_nx = '0;
                    end
                end
            end
            WAIT: begin
                if (data_rdy) begin
                    rdy_nx[gnt] = 1'b1;
                    st_nx       = IDLE;
                end else if (wcnt == 10'(TIMEOUT-1)) begin
                    // TIMEOUT-th WAIT cycle without data: give up silently
                    // and let the client re-arbitrate if it still wants it.
                    terr_nx = 1'b1;
                    st_nx   = IDLE;
                end else begin
                    wcnt_nx = wcnt + 1'b1;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            gnt         <= '0;
            ptr         <= '0;
            wcnt        <= '0;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            ack         <= '0;
            rdy         <= '0;
            timeout_err <= 1'b0;
        end else begin
            st          <= st_nx;
            gnt         <= gnt_nx;
            ptr         <= ptr_nx;
            wcnt        <= wcnt_nx;
            sdram_req   <= sreq_nx;
            sdram_addr  <= saddr_nx;
            ack         <= ack_nx;
            rdy         <= rdy_nx;
            timeout_err <= terr_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench for jtframe_rom_arb (N=4, AW=22, TIMEOUT=1023).
// Inputs are driven and outputs sampled on the falling edge of clk_rom.
module tb_jtframe_rom_arb;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int TO = 1023;

    logic                 clk_rom = 1'b0;
    logic                 rst     = 1'b1;
    logic [N-1:0]         req     = '0;
    logic [N-1:0][AW-1:0] a       = '0;
    logic [N*AW-1:0]      addr;
    logic [N-1:0]         ack, rdy;
    logic                 downloading = 1'b0;
    logic                 sdram_req;
    logic [AW-1:0]        sdram_addr;
    logic                 sdram_ack = 1'b0;
    logic                 data_rdy  = 1'b0;
    logic                 busy, timeout_err;

    int nchk = 0;
    int nerr = 0;

    assign addr = a;

    always #5 clk_rom = ~clk_rom;

    jtframe_rom_arb #(.N(N), .AW(AW), .TIMEOUT(TO)) dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .req         (req),
        .addr        (addr),
        .ack         (ack),
        .rdy         (rdy),
        .downloading (downloading),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_rom);
    endtask

    task automatic clr();
        req = '0; sdram_ack = 1'b0; data_rdy = 1'b0; downloading = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int got, cyc, c;
        logic seen;
        logic [3:0] exp_oh;

        // reset state
        tick();
        chk("rst_sreq",  32'(sdram_req),   0);
        chk("rst_saddr", 32'(sdram_addr),  0);
        chk("rst_ack",   32'(ack),         0);
        chk("rst_rdy",   32'(rdy),         0);
        chk("rst_busy",  32'(busy),        0);
        chk("rst_terr",  32'(timeout_err), 0);
        rst = 1'b0;

        // 1: single client 2, address held after grant despite client change
        a[2] = 22'h12345; req = 4'b0100;
        tick();
        chk("t1_sreq",  32'(sdram_req),  1);
        chk("t1_saddr", 32'(sdram_addr), 32'h12345);
        chk("t1_busy",  32'(busy),       1);
        a[2] = 22'h3FFFF;
        tick();
        chk("t1_saddr_hold", 32'(sdram_addr), 32'h12345);
        tick();
        sdram_ack = 1'b1;
        tick();
        chk("t1_ack",      32'(ack),       32'b0100);
        chk("t1_sreq_off", 32'(sdram_req), 0);
        sdram_ack = 1'b0; req = '0;
        tick();
        chk("t1_ack_pulse", 32'(ack), 0);
        tick();
        data_rdy = 1'b1;
        tick();
        chk("t1_rdy",  32'(rdy),  32'b0100);
        chk("t1_idle", 32'(busy), 0);
        data_rdy = 1'b0;
        tick();
        chk("t1_rdy_pulse", 32'(rdy),       0);
        chk("t1_sreq_end",  32'(sdram_req), 0);

        // 2: fairness with an instant ack+data_rdy controller
        do_reset();
        req = 4'b1111;
        got = 0; cyc = 0;
        while (got < 64 && cyc < 400) begin
            if (ack != '0) begin
                exp_oh = 4'b0001 << (got % 4);
                chk("t2_ack", 32'(ack), 32'(exp_oh));
                chk("t2_rdy", 32'(rdy), 32'(exp_oh));
                got++;
            end
            sdram_ack = sdram_req;
            data_rdy  = sdram_req;
            tick();
            cyc++;
        end
        chk("t2_count", 32'(got), 64);

        // 3: download gating, in-flight completion
        do_reset();
        a[0] = 22'h00ABC; a[1] = 22'h01DEF;
        downloading = 1'b1; req = 4'b0011;
        seen = 1'b0;
        repeat (100) begin tick(); seen |= sdram_req; end
        chk("t3_gate", 32'(seen), 0);
        downloading = 1'b0;
        tick();
        chk("t3_sreq",  32'(sdram_req),  1);
        chk("t3_saddr", 32'(sdram_addr), 32'h00ABC);
        sdram_ack = 1'b1;
        tick();
        chk("t3_ack", 32'(ack), 32'b0001);
        sdram_ack = 1'b0; downloading = 1'b1;
        repeat (3) tick();
        data_rdy = 1'b1;
        tick();
        chk("t3_rdy", 32'(rdy), 32'b0001);
        data_rdy = 1'b0;
        seen = 1'b0;
        repeat (20) begin tick(); seen |= sdram_req; end
        chk("t3_nogrant", 32'(seen), 0);
        chk("t3_busy",    32'(busy), 0);

        // 4: watchdog on client 1
        do_reset();
        a[1] = 22'h2AAAA; req = 4'b0010;
        tick();
        chk("t4_saddr", 32'(sdram_addr), 32'h2AAAA);
        sdram_ack = 1'b1;
        tick();
        chk("t4_ack", 32'(ack), 32'b0010);
        sdram_ack = 1'b0;
        c = 0; seen = 1'b0;
        while (!timeout_err && c < 1100) begin
            tick(); c++;
            seen |= |rdy;
        end
        chk("t4_wd_cycles", 32'(c),    TO);
        chk("t4_no_rdy",    32'(seen), 0);
        chk("t4_idle",      32'(busy), 0);
        tick();
        chk("t4_terr_pulse", 32'(timeout_err), 0);
        chk("t4_regrant",    32'(sdram_req),   1);
        chk("t4_re_saddr",   32'(sdram_addr),  32'h2AAAA);
        sdram_ack = 1'b1;
        tick();
        chk("t4_re_ack", 32'(ack), 32'b0010);
        sdram_ack = 1'b0; req = '0; data_rdy = 1'b1;
        tick();
        chk("t4_re_rdy", 32'(rdy), 32'b0010);
        clr();

        // 5: coincident sdram_ack + data_rdy
        do_reset();
        a[3] = 22'h3ABCD; req = 4'b1000;
        tick();
        chk("t5_saddr", 32'(sdram_addr), 32'h3ABCD);
        sdram_ack = 1'b1; data_rdy = 1'b1;
        tick();
        chk("t5_ack",  32'(ack),  32'b1000);
        chk("t5_rdy",  32'(rdy),  32'b1000);
        chk("t5_idle", 32'(busy), 0);
        clr();
        tick();
        chk("t5_ack_pulse", 32'(ack), 0);

        // 6: async reset during WAIT, stray data_rdy afterwards
        do_reset();
        req = 4'b0001;
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("t6_wait_busy", 32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_busy",  32'(busy),        0);
        chk("t6_sreq",  32'(sdram_req),   0);
        chk("t6_saddr", 32'(sdram_addr),  0);
        chk("t6_ack",   32'(ack),         0);
        chk("t6_terr",  32'(timeout_err), 0);
        tick();
        rst = 1'b0; req = '0; data_rdy = 1'b1;
        tick();
        chk("t6_stray_rdy", 32'(rdy), 0);
        data_rdy = 1'b0;
        tick();
        chk("t6_rdy_after", 32'(rdy),  0);
        chk("t6_idle",      32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
        $finish;
    end

endmodule
